// File: rtl/host_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// host_axi_mem_responder
//
// AXI4 slave memory model for the host_axi master port. It holds a
// word-addressed 32-bit RAM and services one burst at a time. FIXED, INCR and
// WRAP bursts are supported, and writes honour byte strobes. Reads and writes
// take turns when both are requested in the same cycle.
//
// Optional feature (compile-time macro AXI_MEM_DECERR_EN):
//   defined   - a start address with any bit in [31:MEM_AW+2] set returns
//               DECERR; write data is dropped and read data is zero.
//   undefined - upper address bits alias; responses are always OKAY.
//
// Ports:
//   host_clk, host_rst_n      clock, asynchronous active-low reset
//   host_axi_aw*              write address channel (slave side)
//   host_axi_w*               write data channel
//   host_axi_b*               write response channel
//   host_axi_ar*              read address channel
//   host_axi_r*               read data channel
//   dbg_state_o               current FSM state (IDLE=0, WDATA=1, WRESP=2, RDATA=3)
//
// Handshake rule: a transfer happens on a rising edge where valid && ready are
// both high. Once the slave raises a valid, it keeps it high with the payload
// stable until ready is seen.
// -----------------------------------------------------------------------------
module host_axi_mem_responder #(
    parameter int MEM_AW   = 16,
    parameter int ID_WIDTH = 1
) (
    input  logic                host_clk,
    input  logic                host_rst_n,
    input  logic                host_axi_awvalid,
    output logic                host_axi_awready,
    input  logic [31:0]         host_axi_awaddr,
    input  logic [ID_WIDTH-1:0] host_axi_awid,
    input  logic [7:0]          host_axi_awlen,
    input  logic [1:0]          host_axi_awburst,
    input  logic                host_axi_wvalid,
    output logic                host_axi_wready,
    input  logic [31:0]         host_axi_wdata,
    input  logic [3:0]          host_axi_wstrb,
    input  logic                host_axi_wlast,
    output logic                host_axi_bvalid,
    input  logic                host_axi_bready,
    output logic [1:0]          host_axi_bresp,
    output logic [ID_WIDTH-1:0] host_axi_bid,
    input  logic                host_axi_arvalid,
    output logic                host_axi_arready,
    input  logic [31:0]         host_axi_araddr,
    input  logic [ID_WIDTH-1:0] host_axi_arid,
    input  logic [7:0]          host_axi_arlen,
    input  logic [1:0]          host_axi_arburst,
    output logic                host_axi_rvalid,
    input  logic                host_axi_rready,
    output logic [31:0]         host_axi_rdata,
    output logic [1:0]          host_axi_rresp,
    output logic [ID_WIDTH-1:0] host_axi_rid,
    output logic                host_axi_rlast,
    output logic [1:0]          dbg_state_o
);

    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_WRESP = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [31:0]         mem [DEPTH];
    logic [MEM_AW-1:0]   addr_q;
    logic [MEM_AW-1:0]   addr_nxt;
    logic [MEM_AW-1:0]   addr_inc;
    logic [MEM_AW-1:0]   wrap_mask;
    logic [ID_WIDTH-1:0] id_q;
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;
    logic [1:0]          burst_q;
    logic [1:0]          bresp_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic                dec_q;
    logic                prefer_rd_q;

    logic grant_w;
    logic aw_hs, ar_hs, w_hs, r_hs;
    logic last_beat;
    logic wlast_bad;
    logic aw_dec, ar_dec;

`ifdef AXI_MEM_DECERR_EN
    assign aw_dec = |host_axi_awaddr[31:MEM_AW+2];
    assign ar_dec = |host_axi_araddr[31:MEM_AW+2];
    logic unused_addr_bits;
    assign unused_addr_bits = ^{host_axi_awaddr[1:0], host_axi_araddr[1:0]};
`else
    assign aw_dec = 1'b0;
    assign ar_dec = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{host_axi_awaddr[31:MEM_AW+2], host_axi_awaddr[1:0],
                                host_axi_araddr[31:MEM_AW+2], host_axi_araddr[1:0]};
`endif

    // Write wins unless the previously accepted burst was a write.
    assign grant_w   = host_axi_awvalid && (!host_axi_arvalid || !prefer_rd_q);
    assign aw_hs     = host_axi_awvalid && host_axi_awready;
    assign ar_hs     = host_axi_arvalid && host_axi_arready;
    assign w_hs      = host_axi_wvalid  && host_axi_wready;
    assign r_hs      = host_axi_rvalid  && host_axi_rready;
    assign last_beat = (cnt_q == len_q);
    assign wlast_bad = (host_axi_wlast != last_beat);

    assign host_axi_bresp = bresp_q;
    assign host_axi_bid   = id_q;
    assign host_axi_rid   = id_q;
    assign host_axi_rdata = rdata_q;
    assign dbg_state_o    = state_q;

    // State register
    always_ff @(posedge host_clk or negedge host_rst_n) begin
        if (!host_rst_n) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (aw_hs)      state_d = S_WDATA;
                else if (ar_hs) state_d = S_RDATA;
            end
            S_WDATA: if (w_hs && last_beat)            state_d = S_WRESP;
            S_WRESP: if (host_axi_bready)              state_d = S_IDLE;
            S_RDATA: if (host_axi_rready && last_beat) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        host_axi_awready = 1'b0;
        host_axi_arready = 1'b0;
        host_axi_wready  = 1'b0;
        host_axi_bvalid  = 1'b0;
        host_axi_rvalid  = 1'b0;
        host_axi_rlast   = 1'b0;
        host_axi_rresp   = 2'b00;
        case (state_q)
            S_IDLE: begin
                host_axi_awready = grant_w;
                host_axi_arready = host_axi_arvalid && !grant_w;
            end
            S_WDATA: host_axi_wready = 1'b1;
            S_WRESP: host_axi_bvalid = 1'b1;
            S_RDATA: begin
                host_axi_rvalid = 1'b1;
                host_axi_rlast  = last_beat;
                host_axi_rresp  = dec_q ? 2'b11 : 2'b00;
            end
            default: ;
        endcase
    end

    // Address of the following beat. WRAP keeps the upper bits of the word
    // address and only steps the low bits covered by the (len+1)-word window.
    always_comb begin
        addr_inc  = addr_q + 1'b1;
        wrap_mask = MEM_AW'(len_q[3:0]);
        case (burst_q)
            2'b00: addr_nxt = addr_q;
            2'b10: begin
                if (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15)
                    addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
                else
                    addr_nxt = addr_inc;
            end
            default: addr_nxt = addr_inc;
        endcase
    end

    // Burst context and registered response payload
    always_ff @(posedge host_clk or negedge host_rst_n) begin
        if (!host_rst_n) begin
            addr_q      <= '0;
            id_q        <= '0;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            burst_q     <= 2'b00;
            bresp_q     <= 2'b00;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            dec_q       <= 1'b0;
            prefer_rd_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (aw_hs) begin
                        addr_q      <= host_axi_awaddr[MEM_AW+1:2];
                        id_q        <= host_axi_awid;
                        len_q       <= host_axi_awlen;
                        burst_q     <= host_axi_awburst;
                        cnt_q       <= 8'd0;
                        err_q       <= 1'b0;
                        dec_q       <= aw_dec;
                        prefer_rd_q <= 1'b1;
                    end else if (ar_hs) begin
                        addr_q      <= host_axi_araddr[MEM_AW+1:2];
                        id_q        <= host_axi_arid;
                        len_q       <= host_axi_arlen;
                        burst_q     <= host_axi_arburst;
                        cnt_q       <= 8'd0;
                        err_q       <= 1'b0;
                        dec_q       <= ar_dec;
                        prefer_rd_q <= 1'b0;
                        // First beat is fetched here so rvalid can rise next cycle.
                        rdata_q     <= ar_dec ? 32'd0 : mem[host_axi_araddr[MEM_AW+1:2]];
                    end
                end
                S_WDATA: begin
                    if (w_hs) begin
                        addr_q <= addr_nxt;
                        cnt_q  <= cnt_q + 8'd1;
                        err_q  <= err_q | wlast_bad;
                        if (last_beat) begin
                            if (dec_q)                  bresp_q <= 2'b11;
                            else if (err_q | wlast_bad) bresp_q <= 2'b10;
                            else                        bresp_q <= 2'b00;
                        end
                    end
                end
                S_WRESP: if (host_axi_bready) bresp_q <= 2'b00;
                S_RDATA: begin
                    if (r_hs && !last_beat) begin
                        addr_q  <= addr_nxt;
                        cnt_q   <= cnt_q + 8'd1;
                        rdata_q <= dec_q ? 32'd0 : mem[addr_nxt];
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge host_clk) begin
        if (w_hs && !dec_q) begin
            for (int b = 0; b < 4; b++) begin
                if (host_axi_wstrb[b]) mem[addr_q][8*b +: 8] <= host_axi_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_host_axi_mem_responder.sv
module tb_host_axi_mem_responder;

    localparam int TMO = 200;
    localparam logic [1:0] B_FIXED = 2'b00;
    localparam logic [1:0] B_INCR  = 2'b01;
    localparam logic [1:0] B_WRAP  = 2'b10;

    logic        host_clk = 1'b0;
    logic        host_rst_n = 1'b0;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [0:0]  awid, arid, bid, rid;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp, dbg_state;
    logic [3:0]  wstrb;

    host_axi_mem_responder #(.MEM_AW(16), .ID_WIDTH(1)) dut (
        .host_clk         (host_clk),
        .host_rst_n       (host_rst_n),
        .host_axi_awvalid (awvalid),
        .host_axi_awready (awready),
        .host_axi_awaddr  (awaddr),
        .host_axi_awid    (awid),
        .host_axi_awlen   (awlen),
        .host_axi_awburst (awburst),
        .host_axi_wvalid  (wvalid),
        .host_axi_wready  (wready),
        .host_axi_wdata   (wdata),
        .host_axi_wstrb   (wstrb),
        .host_axi_wlast   (wlast),
        .host_axi_bvalid  (bvalid),
        .host_axi_bready  (bready),
        .host_axi_bresp   (bresp),
        .host_axi_bid     (bid),
        .host_axi_arvalid (arvalid),
        .host_axi_arready (arready),
        .host_axi_araddr  (araddr),
        .host_axi_arid    (arid),
        .host_axi_arlen   (arlen),
        .host_axi_arburst (arburst),
        .host_axi_rvalid  (rvalid),
        .host_axi_rready  (rready),
        .host_axi_rdata   (rdata),
        .host_axi_rresp   (rresp),
        .host_axi_rid     (rid),
        .host_axi_rlast   (rlast),
        .dbg_state_o      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 host_clk = ~host_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [35:0] exp_r_q[$];   // {rresp, rid, rlast, rdata}
    logic [2:0]  exp_b_q[$];   // {bresp, bid}
    logic        order_q[$];   // 0 = AW accepted, 1 = AR accepted
    int          w_beats = 0;
    logic [31:0] wbuf[16];
    logic [3:0]  sbuf[16];
    logic [31:0] rbuf[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no handshake seen, required within %0d cycles", name, TMO);
    endtask

    // ---------------- monitor ----------------
    always @(negedge host_clk) begin
        if (host_rst_n) begin
            if (rvalid && rready) begin
                if (exp_r_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL r_unexpected: got beat 0x%0h, expected no beat", rdata);
                end else begin
                    check("r_beat", 64'({rresp, rid, rlast, rdata}), 64'(exp_r_q.pop_front()));
                end
            end
            if (bvalid && bready) begin
                if (exp_b_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_unexpected: got bresp %0b, expected no response", bresp);
                end else begin
                    check("b_resp", 64'({bresp, bid}), 64'(exp_b_q.pop_front()));
                end
            end
            if (wvalid && wready) w_beats++;
            if (awvalid && awready) order_q.push_back(1'b0);
            if (arvalid && arready) order_q.push_back(1'b1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_aw(input logic [31:0] addr, input logic id, input logic [7:0] len,
                           input logic [1:0] burst);
        int cyc = 0;
        awaddr = addr; awid = id; awlen = len; awburst = burst; awvalid = 1'b1;
        @(negedge host_clk);
        while (!awready && cyc < TMO) begin @(negedge host_clk); cyc++; end
        if (!awready) timeout_fail("aw_accept");
        @(posedge host_clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic id, input logic [7:0] len,
                           input logic [1:0] burst);
        int cyc = 0;
        araddr = addr; arid = id; arlen = len; arburst = burst; arvalid = 1'b1;
        @(negedge host_clk);
        while (!arready && cyc < TMO) begin @(negedge host_clk); cyc++; end
        if (!arready) timeout_fail("ar_accept");
        @(posedge host_clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int cyc = 0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        @(negedge host_clk);
        while (!wready && cyc < TMO) begin @(negedge host_clk); cyc++; end
        if (!wready) timeout_fail("w_accept");
        @(posedge host_clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic id, input logic [7:0] len,
                            input logic [1:0] burst, input logic [1:0] exp_resp,
                            input logic [15:0] lmask);
        int cyc = 0;
        exp_b_q.push_back({exp_resp, id});
        send_aw(addr, id, len, burst);
        for (int i = 0; i <= int'(len); i++) send_w(wbuf[i], sbuf[i], lmask[i]);
        @(negedge host_clk);
        while (!bvalid && cyc < TMO) begin @(negedge host_clk); cyc++; end
        if (!bvalid) timeout_fail("b_wait");
        @(posedge host_clk); #1;
    endtask

    task automatic push_r(input logic id, input logic [7:0] len);
        for (int i = 0; i <= int'(len); i++)
            exp_r_q.push_back({2'b00, id, (i == int'(len)), rbuf[i]});
    endtask

    task automatic drain_r();
        int cyc = 0;
        while (exp_r_q.size() != 0 && cyc < TMO) begin @(negedge host_clk); cyc++; end
        if (exp_r_q.size() != 0) begin
            timeout_fail("r_drain");
            exp_r_q.delete();
        end
        @(posedge host_clk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic id, input logic [7:0] len,
                           input logic [1:0] burst);
        push_r(id, len);
        send_ar(addr, id, len, burst);
        drain_r();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awready"}, 64'(awready), 64'd0);
        check({tag, "_arready"}, 64'(arready), 64'd0);
        check({tag, "_wready"},  64'(wready),  64'd0);
        check({tag, "_bvalid"},  64'(bvalid),  64'd0);
        check({tag, "_rvalid"},  64'(rvalid),  64'd0);
        check({tag, "_rlast"},   64'(rlast),   64'd0);
        check({tag, "_bresp"},   64'(bresp),   64'd0);
        check({tag, "_rresp"},   64'(rresp),   64'd0);
        check({tag, "_rdata"},   64'(rdata),   64'd0);
        check({tag, "_ids"},     64'({bid, rid}), 64'd0);
        check({tag, "_state"},   64'(dbg_state), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        int hs;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 1;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arburst = 0; rready = 1;

        repeat (3) @(posedge host_clk);
        #1;
        check_idle_outputs("reset");
        @(posedge host_clk); #1;
        host_rst_n = 1'b1;
        @(posedge host_clk); #1;

        // 1: INCR write then readback with rlast only on beat 3
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; rbuf[i] = 32'(i + 1); end
        do_write(32'h10, 1'b1, 8'd3, B_INCR, 2'b00, 16'h0008);
        do_read(32'h10, 1'b1, 8'd3, B_INCR);

        // 2: partial strobe merge
        wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
        do_write(32'h20, 1'b0, 8'd0, B_INCR, 2'b00, 16'h0001);
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'h3;
        do_write(32'h20, 1'b0, 8'd0, B_INCR, 2'b00, 16'h0001);
        rbuf[0] = 32'h1122CCDD;
        do_read(32'h20, 1'b0, 8'd0, B_INCR);

        // 3: WRAP window 0x10..0x1C starting at 0x18, then FIXED
        rbuf[0] = 32'd3; rbuf[1] = 32'd4; rbuf[2] = 32'd1; rbuf[3] = 32'd2;
        do_read(32'h18, 1'b1, 8'd3, B_WRAP);
        rbuf[0] = 32'd2; rbuf[1] = 32'd2; rbuf[2] = 32'd2;
        do_read(32'h14, 1'b0, 8'd2, B_FIXED);

        // 4: arbitration; reset re-arms write priority
        host_rst_n = 1'b0;
        repeat (2) @(posedge host_clk);
        #1 host_rst_n = 1'b1;
        @(posedge host_clk); #1;
        order_q.delete();
        wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        rbuf[0] = 32'd1; rbuf[1] = 32'd2;
        fork
            do_write(32'h40, 1'b0, 8'd1, B_INCR, 2'b00, 16'h0002);
            do_read(32'h10, 1'b1, 8'd1, B_INCR);
        join
        check("arb1_count", 64'(order_q.size()), 64'd2);
        if (order_q.size() == 2) begin
            check("arb1_first", 64'(order_q[0]), 64'd0);
            check("arb1_second", 64'(order_q[1]), 64'd1);
        end
        // A lone write makes write the last-served channel, so read wins next.
        wbuf[0] = 32'h55; sbuf[0] = 4'hF;
        do_write(32'h48, 1'b0, 8'd0, B_FIXED, 2'b00, 16'h0001);
        order_q.delete();
        wbuf[0] = 32'hB0;
        rbuf[0] = 32'hA0; rbuf[1] = 32'hA1;
        fork
            do_write(32'h40, 1'b1, 8'd0, B_INCR, 2'b00, 16'h0001);
            do_read(32'h40, 1'b0, 8'd1, B_INCR);
        join
        check("arb2_count", 64'(order_q.size()), 64'd2);
        if (order_q.size() == 2) begin
            check("arb2_first", 64'(order_q[0]), 64'd1);
            check("arb2_second", 64'(order_q[1]), 64'd0);
        end
        rbuf[0] = 32'hB0; rbuf[1] = 32'hA1; rbuf[2] = 32'h55;
        do_read(32'h40, 1'b1, 8'd2, B_INCR);

        // 5a: back-pressure holds beat 2 stable
        for (int i = 0; i < 4; i++) rbuf[i] = 32'(i + 1);
        push_r(1'b0, 8'd3);
        send_ar(32'h10, 1'b0, 8'd3, B_INCR);
        cyc = 0; hs = 0;
        while (hs < 2 && cyc < TMO) begin
            @(negedge host_clk); cyc++;
            if (rvalid && rready) hs++;
        end
        if (hs < 2) timeout_fail("stall_setup");
        @(posedge host_clk); #1;
        rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge host_clk);
            check("stall_rvalid", 64'(rvalid), 64'd1);
            check("stall_rdata", 64'(rdata), 64'd3);
            check("stall_rlast", 64'(rlast), 64'd0);
        end
        @(posedge host_clk); #1;
        rready = 1'b1;
        drain_r();

        // 5b: early wlast -> 4 beats, SLVERR; late wlast -> 2 beats, SLVERR
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0 + 32'(i); sbuf[i] = 4'hF; rbuf[i] = 32'hC0 + 32'(i); end
        w_beats = 0;
        do_write(32'h80, 1'b1, 8'd3, B_INCR, 2'b10, 16'h0002);
        check("wlast_early_beats", 64'(w_beats), 64'd4);
        check("wlast_early_wready", 64'(wready), 64'd0);
        do_read(32'h80, 1'b1, 8'd3, B_INCR);
        w_beats = 0;
        do_write(32'h90, 1'b0, 8'd1, B_INCR, 2'b10, 16'h0000);
        check("wlast_missing_beats", 64'(w_beats), 64'd2);

        // 6: reset in the middle of a read burst
        for (int i = 0; i < 4; i++) rbuf[i] = 32'(i + 1);
        push_r(1'b0, 8'd3);
        send_ar(32'h10, 1'b0, 8'd3, B_INCR);
        cyc = 0; hs = 0;
        while (hs < 2 && cyc < TMO) begin
            @(negedge host_clk); cyc++;
            if (rvalid && rready) hs++;
        end
        if (hs < 2) timeout_fail("rst_setup");
        @(posedge host_clk); #2;
        host_rst_n = 1'b0;
        #1;
        check("rst_mid_rvalid", 64'(rvalid), 64'd0);
        check("rst_mid_rdata", 64'(rdata), 64'd0);
        exp_r_q.delete();
        repeat (2) @(posedge host_clk);
        #1 host_rst_n = 1'b1;
        #1;
        check_idle_outputs("post_rst");
        @(posedge host_clk); #1;
        do_read(32'h10, 1'b0, 8'd3, B_INCR);
        rbuf[0] = 32'h1122CCDD;
        do_read(32'h20, 1'b1, 8'd0, B_INCR);

        repeat (3) @(posedge host_clk);
        check("end_r_queue_empty", 64'(exp_r_q.size()), 64'd0);
        check("end_b_queue_empty", 64'(exp_b_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
